// File: rtl/coffee_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : coffee_pkg
//  Description : Shared definitions for the coffee vending controller.
//                Covers the FSM state encoding, coin values in 10-peso
//                units and the change-dispenser coin codes.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package coffee_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_BREW   = 2'd2,
        ST_CHANGE = 2'd3
    } state_t;

    // Coin values, in 10-peso units
    localparam logic [3:0] c_val_t = 4'd1;
    localparam logic [3:0] c_val_w = 4'd2;
    localparam logic [3:0] c_val_f = 4'd5;

    // Change dispenser coin codes
    localparam logic [1:0] c_code_none = 2'b00;
    localparam logic [1:0] c_code_t    = 2'b01;
    localparam logic [1:0] c_code_w    = 2'b10;
    localparam logic [1:0] c_code_f    = 2'b11;

endpackage : coffee_pkg
`default_nettype wire

// File: rtl/change_picker.sv
`default_nettype none
// ============================================================================
//  Module      : change_picker
//  Description : Greedy change-coin choice for a remaining credit. Picks
//                the largest coin not exceeding the credit and reports both
//                its dispenser code and its value.
//  Ports       : credit    in  4  remaining credit (10-peso units)
//                coin_code out 2  dispenser code (00 when credit is 0)
//                coin_val  out 4  value of that coin (10-peso units)
//  Revision    : 1.0 - initial release
// ============================================================================
module change_picker
    import coffee_pkg::*;
(
    input  logic [3:0] credit,
    output logic [1:0] coin_code,
    output logic [3:0] coin_val
);

    always_comb begin
        coin_code = c_code_none;
        coin_val  = 4'd0;
        if (credit >= c_val_f) begin
            coin_code = c_code_f;
            coin_val  = c_val_f;
        end else if (credit >= c_val_w) begin
            coin_code = c_code_w;
            coin_val  = c_val_w;
        end else if (credit >= c_val_t) begin
            coin_code = c_code_t;
            coin_val  = c_val_t;
        end
    end

endmodule : change_picker
`default_nettype wire

// File: rtl/coffee_vend_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : coffee_vend_ctrl
//  Description : Coffee vending controller. Accumulates coin credit,
//                validates a two-way selection against its price, runs the
//                brew request/done handshake and pays change greedily over
//                a valid/ready handshake.
//  Ports       : clk, rst_n               clock, async active-low reset
//                coin_t/coin_w/coin_f     10/20/50-peso coin pulses
//                sel_valid, sel           selection strobe and choice
//                cancel                   refund request pulse
//                brew_done                brew unit finished pulse
//                chg_ready                dispenser accepts offered coin
//                brew_req, brew_sel       brew request and latched choice
//                chg_valid, chg_coin      change coin offer and its code
//                credit                   current credit (10-peso units)
//                coin_reject, sel_reject  one-cycle refusal pulses
//                busy                     high while brewing or paying
//  Revision    : 1.0 - initial release
// ============================================================================
module coffee_vend_ctrl
    import coffee_pkg::*;
#(
    parameter int PRICE0     = 3,
    parameter int PRICE1     = 4,
    parameter int MAX_CREDIT = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_t,
    input  logic       coin_w,
    input  logic       coin_f,
    input  logic       sel_valid,
    input  logic       sel,
    input  logic       cancel,
    input  logic       brew_done,
    input  logic       chg_ready,
    output logic       brew_req,
    output logic       brew_sel,
    output logic       chg_valid,
    output logic [1:0] chg_coin,
    output logic [3:0] credit,
    output logic       coin_reject,
    output logic       sel_reject,
    output logic       busy
);

    state_t     r_state;
    logic [3:0] r_credit;
    logic       r_brew_sel;
    logic       r_coin_reject;
    logic       r_sel_reject;

    logic [1:0] w_coin_cnt;
    logic       w_coin_any;
    logic [3:0] w_coin_val;
    logic [4:0] w_sum;
    logic [3:0] w_price;
    logic       w_cancel_take;
    logic       w_sel_take;
    logic       w_coin_take;
    logic [1:0] w_chg_code;
    logic [3:0] w_chg_val;

    change_picker u_picker (
        .credit    (r_credit),
        .coin_code (w_chg_code),
        .coin_val  (w_chg_val)
    );

    assign w_coin_cnt = {1'b0, coin_t} + {1'b0, coin_w} + {1'b0, coin_f};
    assign w_coin_any = coin_t | coin_w | coin_f;

    always_comb begin
        w_coin_val = 4'd0;
        if (coin_f)      w_coin_val = c_val_f;
        else if (coin_w) w_coin_val = c_val_w;
        else if (coin_t) w_coin_val = c_val_t;
    end

    // One extra bit so an overflowing sum is still compared correctly
    assign w_sum   = {1'b0, r_credit} + {1'b0, w_coin_val};
    assign w_price = sel ? 4'(PRICE1) : 4'(PRICE0);

    // cancel outranks selection, which outranks coins
    assign w_cancel_take = (r_state == ST_CREDIT) && cancel;
    assign w_sel_take    = (r_state == ST_CREDIT) && sel_valid && !cancel
                           && (r_credit >= w_price);
    assign w_coin_take   = ((r_state == ST_IDLE) || (r_state == ST_CREDIT))
                           && !w_cancel_take && !w_sel_take
                           && (w_coin_cnt == 2'd1)
                           && (w_sum <= 5'(MAX_CREDIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_credit      <= 4'd0;
            r_brew_sel    <= 1'b0;
            r_coin_reject <= 1'b0;
            r_sel_reject  <= 1'b0;
        end else begin
            r_coin_reject <= w_coin_any && !w_coin_take;
            r_sel_reject  <= sel_valid && !w_sel_take;
            case (r_state)
                ST_IDLE, ST_CREDIT: begin
                    if (w_cancel_take) begin
                        // CREDIT always holds a non-zero credit here
                        r_state <= ST_CHANGE;
                    end else if (w_sel_take) begin
                        r_credit   <= r_credit - w_price;
                        r_brew_sel <= sel;
                        r_state    <= ST_BREW;
                    end else if (w_coin_take) begin
                        r_credit <= w_sum[3:0];
                        r_state  <= ST_CREDIT;
                    end
                end
                ST_BREW: begin
                    if (brew_done) begin
                        r_state <= (r_credit != 4'd0) ? ST_CHANGE : ST_IDLE;
                    end
                end
                ST_CHANGE: begin
                    if (chg_ready) begin
                        r_credit <= r_credit - w_chg_val;
                        if (r_credit == w_chg_val) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Handshake outputs are decoded from the state register so the async
    // reset removes them without waiting for a clock edge.
    assign brew_req    = (r_state == ST_BREW);
    assign chg_valid   = (r_state == ST_CHANGE);
    assign busy        = (r_state == ST_BREW) || (r_state == ST_CHANGE);
    assign chg_coin    = chg_valid ? w_chg_code : c_code_none;
    assign credit      = r_credit;
    assign brew_sel    = r_brew_sel;
    assign coin_reject = r_coin_reject;
    assign sel_reject  = r_sel_reject;

endmodule : coffee_vend_ctrl
`default_nettype wire

// File: tb/tb_coffee_vend_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_coffee_vend_ctrl
//  Description : Self-checking bench for coffee_vend_ctrl. A table of
//                per-cycle input/expected-output records drives the main
//                flows; reset behaviour is checked by hand-written steps.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_coffee_vend_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       coin_t, coin_w, coin_f, sel_valid, sel, cancel, brew_done, chg_ready;
    logic       brew_req, brew_sel, chg_valid, coin_reject, sel_reject, busy;
    logic [1:0] chg_coin;
    logic [3:0] credit;

    int checks   = 0;
    int failures = 0;

    coffee_vend_ctrl #(.PRICE0(3), .PRICE1(4), .MAX_CREDIT(9)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .coin_t      (coin_t),
        .coin_w      (coin_w),
        .coin_f      (coin_f),
        .sel_valid   (sel_valid),
        .sel         (sel),
        .cancel      (cancel),
        .brew_done   (brew_done),
        .chg_ready   (chg_ready),
        .brew_req    (brew_req),
        .brew_sel    (brew_sel),
        .chg_valid   (chg_valid),
        .chg_coin    (chg_coin),
        .credit      (credit),
        .coin_reject (coin_reject),
        .sel_reject  (sel_reject),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // inp : {coin_t, coin_w, coin_f, sel_valid, sel, cancel, brew_done, chg_ready}
    // exp : {credit[3:0], brew_req, brew_sel, chg_valid, chg_coin[1:0],
    //        coin_reject, sel_reject, busy}
    typedef struct {
        string       name;
        logic [7:0]  inp;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [11:0] e(input int cr, input bit breq, input bit bsel,
                                      input bit cval, input int coin, input bit crej,
                                      input bit srej, input bit bsy);
        return {4'(cr), breq, bsel, cval, 2'(coin), crej, srej, bsy};
    endfunction

    function automatic void add(input string n, input logic [7:0] i, input logic [11:0] x);
        vec_t v;
        v.name = n;
        v.inp  = i;
        v.exp  = x;
        vecs.push_back(v);
    endfunction

    function automatic logic [11:0] observed();
        return {credit, brew_req, brew_sel, chg_valid, chg_coin, coin_reject, sel_reject, busy};
    endfunction

    task automatic check(input string n, input logic [11:0] got, input logic [11:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %b expected %b", n, got, want);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        {coin_t, coin_w, coin_f, sel_valid, sel, cancel, brew_done, chg_ready} = v.inp;
        @(posedge clk);
        #1;
        check(v.name, observed(), v.exp);
    endtask

    initial begin
        // F, W, select coffee 0, brew, change 20+20
        add("f_to_5",       8'b001_00_0_0_0, e(5,0,0,0,0,0,0,0));
        add("w_to_7",       8'b010_00_0_0_0, e(7,0,0,0,0,0,0,0));
        add("sel0_ok",      8'b000_10_0_0_0, e(4,1,0,0,0,0,0,1));
        add("brew_hold",    8'b000_00_0_0_0, e(4,1,0,0,0,0,0,1));
        add("brew_done",    8'b000_00_0_1_0, e(4,0,0,1,2,0,0,1));
        add("chg_20_a",     8'b000_00_0_0_1, e(2,0,0,1,2,0,0,1));
        add("chg_20_b",     8'b000_00_0_0_1, e(0,0,0,0,0,0,0,0));
        // T, short selection, cancel refund
        add("t_to_1",       8'b100_00_0_0_0, e(1,0,0,0,0,0,0,0));
        add("sel1_short",   8'b000_11_0_0_0, e(1,0,0,0,0,0,1,0));
        add("cancel_1",     8'b000_00_1_0_0, e(1,0,0,1,1,0,0,1));
        add("chg_10",       8'b000_00_0_0_1, e(0,0,0,0,0,0,0,0));
        // Ceiling and multi-coin rejects
        add("f_to_5b",      8'b001_00_0_0_0, e(5,0,0,0,0,0,0,0));
        add("w_to_7b",      8'b010_00_0_0_0, e(7,0,0,0,0,0,0,0));
        add("w_to_9",       8'b010_00_0_0_0, e(9,0,0,0,0,0,0,0));
        add("t_over_max",   8'b100_00_0_0_0, e(9,0,0,0,0,1,0,0));
        add("w_t_multi",    8'b110_00_0_0_0, e(9,0,0,0,0,1,0,0));
        add("cancel_9",     8'b000_00_1_0_0, e(9,0,0,1,3,0,0,1));
        add("chg9_50",      8'b000_00_0_0_1, e(4,0,0,1,2,0,0,1));
        add("chg4_20",      8'b000_00_0_0_1, e(2,0,0,1,2,0,0,1));
        add("chg2_20",      8'b000_00_0_0_1, e(0,0,0,0,0,0,0,0));
        // Credit 7, sel+cancel together, stalled dispenser
        add("f_to_5c",      8'b001_00_0_0_0, e(5,0,0,0,0,0,0,0));
        add("w_to_7c",      8'b010_00_0_0_0, e(7,0,0,0,0,0,0,0));
        add("sel_cancel",   8'b000_10_1_0_0, e(7,0,0,1,3,0,1,1));
        add("stall_1",      8'b000_00_0_0_0, e(7,0,0,1,3,0,0,1));
        add("stall_2",      8'b000_00_0_0_0, e(7,0,0,1,3,0,0,1));
        add("stall_3",      8'b000_00_0_0_0, e(7,0,0,1,3,0,0,1));
        add("chg7_50",      8'b000_00_0_0_1, e(2,0,0,1,2,0,0,1));
        add("chg2_20b",     8'b000_00_0_0_1, e(0,0,0,0,0,0,0,0));
        // Brew with injected coin/cancel/selection, then park in CHANGE
        add("f_to_5d",      8'b001_00_0_0_0, e(5,0,0,0,0,0,0,0));
        add("sel1_ok",      8'b000_11_0_0_0, e(1,1,1,0,0,0,0,1));
        add("brew_inject",  8'b001_10_1_0_0, e(1,1,1,0,0,1,1,1));
        add("brew_hold2",   8'b000_00_0_0_0, e(1,1,1,0,0,0,0,1));
        add("brew_done2",   8'b000_00_0_1_0, e(1,0,1,1,1,0,0,1));
        add("chg_park",     8'b000_00_0_0_0, e(1,0,1,1,1,0,0,1));
        // After reset: idle strobes, exact-price brew with no change
        add("idle_sel_bd",  8'b000_10_0_1_0, e(0,0,0,0,0,0,1,0));
        add("t_to_1e",      8'b100_00_0_0_0, e(1,0,0,0,0,0,0,0));
        add("w_to_3",       8'b010_00_0_0_0, e(3,0,0,0,0,0,0,0));
        add("sel0_exact",   8'b000_10_0_0_0, e(0,1,0,0,0,0,0,1));
        add("brew_to_idle", 8'b000_00_0_1_0, e(0,0,0,0,0,0,0,0));

        rst_n = 1'b0;
        {coin_t, coin_w, coin_f, sel_valid, sel, cancel, brew_done, chg_ready} = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", observed(), 12'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 34; i++) apply(vecs[i]);

        // Asynchronous reset in the middle of CHANGE, away from any edge
        @(negedge clk);
        {coin_t, coin_w, coin_f, sel_valid, sel, cancel, brew_done, chg_ready} = '0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_now", observed(), 12'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("after_reset_idle", observed(), 12'd0);

        for (int i = 34; i < vecs.size(); i++) apply(vecs[i]);

        @(negedge clk);
        {coin_t, coin_w, coin_f, sel_valid, sel, cancel, brew_done, chg_ready} = '0;
        @(posedge clk);
        #1;
        check("final_idle", observed(), 12'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_coffee_vend_ctrl
`default_nettype wire
